// File: rtl/axis_pkt_tx.sv
// AXI-Stream packet transmitter: one packet of pkt_len beats per start, counter payload.
// Define AXIS_TX_PRBS_EN to use a 16-bit Fibonacci LFSR payload instead (DATA_WIDTH must be 16).
//
// state | meaning
// IDLE  | waiting for start with a non-zero pkt_len
// SEND  | presenting beats, advancing on each m_tvalid & m_tready
// GAP   | idle spacing after a packet; start is ignored
module axis_pkt_tx #(
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 14,
  parameter int GAP_CYCLES = 2
) (
  input  logic                    aclk,
  input  logic                    areset_n,
  input  logic                    start,
  input  logic [LEN_WIDTH-1:0]    pkt_len,
  input  logic [DATA_WIDTH-1:0]   seed,
  output logic                    busy,
  output logic                    tx_done,
  output logic [LEN_WIDTH-1:0]    beat_cnt,
  output logic [DATA_WIDTH-1:0]   m_tdata,
  output logic [DATA_WIDTH/8-1:0] m_tkeep,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic                    m_tlast
);

  localparam int KEEP_W = DATA_WIDTH / 8;
  localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

`ifdef AXIS_TX_PRBS_EN
  if (DATA_WIDTH != 16) begin : g_bad_prbs_width
    $error("axis_pkt_tx: AXIS_TX_PRBS_EN requires DATA_WIDTH == 16");
  end

  function automatic logic [DATA_WIDTH-1:0] next_payload(input logic [DATA_WIDTH-1:0] d);
    return {d[14:0], d[15] ^ d[14] ^ d[12] ^ d[3]};
  endfunction

  // An all-zero seed would lock the LFSR, so it is replaced on load
  function automatic logic [DATA_WIDTH-1:0] load_payload(input logic [DATA_WIDTH-1:0] s);
    return (s == '0) ? DATA_WIDTH'(1) : s;
  endfunction
`else
  function automatic logic [DATA_WIDTH-1:0] next_payload(input logic [DATA_WIDTH-1:0] d);
    return d + DATA_WIDTH'(1);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] load_payload(input logic [DATA_WIDTH-1:0] s);
    return s;
  endfunction
`endif

  state_t                state_q, state_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [GAP_W-1:0]      gap_q, gap_d;
  logic [DATA_WIDTH-1:0] data_d;
  logic [KEEP_W-1:0]     keep_d;
  logic                  valid_d, last_d, busy_d, done_d;
  logic [LEN_WIDTH-1:0]  cnt_d;

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state_q  <= IDLE;
      len_q    <= '0;
      gap_q    <= '0;
      m_tdata  <= '0;
      m_tkeep  <= '0;
      m_tvalid <= 1'b0;
      m_tlast  <= 1'b0;
      busy     <= 1'b0;
      tx_done  <= 1'b0;
      beat_cnt <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      gap_q    <= gap_d;
      m_tdata  <= data_d;
      m_tkeep  <= keep_d;
      m_tvalid <= valid_d;
      m_tlast  <= last_d;
      busy     <= busy_d;
      tx_done  <= done_d;
      beat_cnt <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    gap_d   = gap_q;
    data_d  = m_tdata;
    keep_d  = m_tkeep;
    valid_d = m_tvalid;
    last_d  = m_tlast;
    busy_d  = busy;
    done_d  = tx_done;
    cnt_d   = beat_cnt;

    case (state_q)
      IDLE: begin
        if (start && (pkt_len != '0)) begin
          len_d   = pkt_len;
          data_d  = load_payload(seed);
          keep_d  = '1;
          valid_d = 1'b1;
          last_d  = (pkt_len == LEN_WIDTH'(1));
          busy_d  = 1'b1;
          done_d  = 1'b0;
          cnt_d   = '0;
          state_d = SEND;
        end
      end

      SEND: begin
        if (m_tvalid && m_tready) begin
          if (m_tlast) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            cnt_d   = len_q;
            done_d  = 1'b1;
            if (GAP_CYCLES == 0) begin
              state_d = IDLE;
              busy_d  = 1'b0;
            end else begin
              state_d = GAP;
              gap_d   = GAP_LOAD;
            end
          end else begin
            cnt_d  = beat_cnt + LEN_WIDTH'(1);
            data_d = next_payload(m_tdata);
            // beat_cnt+1 is the index of the beat being loaded now
            last_d = ((beat_cnt + LEN_WIDTH'(1)) == (len_q - LEN_WIDTH'(1)));
          end
        end
      end

      GAP: begin
        if (gap_q == '0) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_axis_pkt_tx.sv
// Directed bench for axis_pkt_tx with default parameters (16-bit data, 14-bit length, 2 gap cycles).
// Compile with +define+AXIS_TX_PRBS_EN to exercise the LFSR payload.
module tb_axis_pkt_tx;

  logic        aclk;
  logic        areset_n;
  logic        start;
  logic [13:0] pkt_len;
  logic [15:0] seed;
  logic        busy;
  logic        tx_done;
  logic [13:0] beat_cnt;
  logic [15:0] m_tdata;
  logic [1:0]  m_tkeep;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;

  int tests_run    = 0;
  int tests_failed = 0;

  axis_pkt_tx #(.DATA_WIDTH(16), .LEN_WIDTH(14), .GAP_CYCLES(2)) dut (
    .aclk     (aclk),
    .areset_n (areset_n),
    .start    (start),
    .pkt_len  (pkt_len),
    .seed     (seed),
    .busy     (busy),
    .tx_done  (tx_done),
    .beat_cnt (beat_cnt),
    .m_tdata  (m_tdata),
    .m_tkeep  (m_tkeep),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tlast  (m_tlast)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
    $fatal(1, "watchdog");
  end

`ifdef AXIS_TX_PRBS_EN
  function automatic logic [15:0] m_next(input logic [15:0] d);
    return {d[14:0], d[15] ^ d[14] ^ d[12] ^ d[3]};
  endfunction
  function automatic logic [15:0] m_load(input logic [15:0] s);
    return (s == 16'h0000) ? 16'h0001 : s;
  endfunction
`else
  function automatic logic [15:0] m_next(input logic [15:0] d);
    return d + 16'h0001;
  endfunction
  function automatic logic [15:0] m_load(input logic [15:0] s);
    return s;
  endfunction
`endif

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 20) begin
      step();
      n++;
    end
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_idle_timeout: busy=%b after %0d cycles, required 0", name, busy, n);
    end
  endtask

  task automatic test_reset();
    areset_n = 1'b0; start = 1'b0; pkt_len = '0; seed = '0; m_tready = 1'b0;
    step(); step();
    tests_run++;
    if ({m_tvalid, m_tlast, busy, tx_done} !== 4'b0000 || m_tdata !== 16'h0 ||
        m_tkeep !== 2'b00 || beat_cnt !== 14'h0) begin
      tests_failed++;
      $display("FAIL reset_values: valid=%b last=%b busy=%b done=%b data=%h keep=%b cnt=%0d, required all zero",
               m_tvalid, m_tlast, busy, tx_done, m_tdata, m_tkeep, beat_cnt);
    end
    areset_n = 1'b1;
    step(); step();
    tests_run++;
    if (m_tvalid !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release_idle: valid=%b busy=%b, required 0 0", m_tvalid, busy);
    end
  endtask

  task automatic test_basic();
    logic [15:0] exp;
    start = 1'b1; pkt_len = 14'd4; seed = 16'h00F0; m_tready = 1'b1;
    step();
    start = 1'b0;
    exp = m_load(16'h00F0);
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (m_tvalid !== 1'b1 || m_tdata !== exp || m_tlast !== (i == 3) || m_tkeep !== 2'b11 ||
          busy !== 1'b1 || tx_done !== 1'b0) begin
        tests_failed++;
        $display("FAIL basic_beat%0d: valid=%b data=%h last=%b keep=%b busy=%b done=%b, required 1 %h %b 11 1 0",
                 i, m_tvalid, m_tdata, m_tlast, m_tkeep, busy, tx_done, exp, (i == 3));
      end
      exp = m_next(exp);
      step();
    end
    tests_run++;
    if (tx_done !== 1'b1 || m_tvalid !== 1'b0 || m_tlast !== 1'b0 || beat_cnt !== 14'd4 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic_done: done=%b valid=%b last=%b cnt=%0d busy=%b, required 1 0 0 4 1",
               tx_done, m_tvalid, m_tlast, beat_cnt, busy);
    end
    step();
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic_gap2_busy: busy=%b, required 1", busy);
    end
    step();
    tests_run++;
    if (busy !== 1'b0 || tx_done !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic_gap_end: busy=%b done=%b, required 0 1", busy, tx_done);
    end
  endtask

  task automatic test_backpressure();
    logic [5:0]  pat = 6'b101001;   // tready per cycle: 1,0,0,1,0,1
    logic [15:0] exp;
    int          hs  = 0;
    int          cyc = 0;
    start = 1'b1; pkt_len = 14'd3; seed = 16'h0100; m_tready = 1'b0;
    step();
    start = 1'b0;
    exp = m_load(16'h0100);
    while (cyc < 20 && hs < 3) begin
      tests_run++;
      if (m_tvalid !== 1'b1 || m_tdata !== exp || m_tlast !== (hs == 2)) begin
        tests_failed++;
        $display("FAIL bp_cycle%0d: valid=%b data=%h last=%b, required 1 %h %b",
                 cyc, m_tvalid, m_tdata, m_tlast, exp, (hs == 2));
      end
      m_tready = (cyc < 6) ? pat[cyc] : 1'b1;
      step();
      if (m_tready) begin
        hs++;
        exp = m_next(exp);
      end
      cyc++;
    end
    m_tready = 1'b1;
    tests_run++;
    if (hs !== 3 || cyc !== 6) begin
      tests_failed++;
      $display("FAIL bp_handshakes: %0d handshakes in %0d cycles, required 3 in 6", hs, cyc);
    end
    tests_run++;
    if (tx_done !== 1'b1 || m_tvalid !== 1'b0 || beat_cnt !== 14'd3) begin
      tests_failed++;
      $display("FAIL bp_done: done=%b valid=%b cnt=%0d, required 1 0 3", tx_done, m_tvalid, beat_cnt);
    end
    wait_idle("bp");
  endtask

  task automatic test_single_and_wrap();
    logic [15:0] exp;
    start = 1'b1; pkt_len = 14'd1; seed = 16'hFFFF; m_tready = 1'b1;
    step();
    start = 1'b0;
    tests_run++;
    if (m_tvalid !== 1'b1 || m_tdata !== m_load(16'hFFFF) || m_tlast !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_beat: valid=%b data=%h last=%b, required 1 %h 1", m_tvalid, m_tdata, m_tlast, m_load(16'hFFFF));
    end
    step();
    tests_run++;
    if (m_tvalid !== 1'b0 || tx_done !== 1'b1 || beat_cnt !== 14'd1) begin
      tests_failed++;
      $display("FAIL single_done: valid=%b done=%b cnt=%0d, required 0 1 1", m_tvalid, tx_done, beat_cnt);
    end
    wait_idle("single");

    start = 1'b1; pkt_len = 14'd2; seed = 16'hFFFF;
    step();
    start = 1'b0;
    exp = m_load(16'hFFFF);
    tests_run++;
    if (m_tdata !== exp || m_tlast !== 1'b0 || tx_done !== 1'b0 || beat_cnt !== 14'd0) begin
      tests_failed++;
      $display("FAIL wrap_beat0: data=%h last=%b done=%b cnt=%0d, required %h 0 0 0", m_tdata, m_tlast, tx_done, beat_cnt, exp);
    end
    step();
    exp = m_next(exp);
    tests_run++;
    if (m_tvalid !== 1'b1 || m_tdata !== exp || m_tlast !== 1'b1) begin
      tests_failed++;
      $display("FAIL wrap_beat1: valid=%b data=%h last=%b, required 1 %h 1", m_tvalid, m_tdata, m_tlast, exp);
    end
    step();
    tests_run++;
    if (tx_done !== 1'b1 || beat_cnt !== 14'd2) begin
      tests_failed++;
      $display("FAIL wrap_done: done=%b cnt=%0d, required 1 2", tx_done, beat_cnt);
    end
    wait_idle("wrap");
  endtask

  task automatic test_ignored_starts();
    logic [15:0] last_data = '0;
    logic [15:0] exp;
    int          hs = 0;
    start = 1'b1; pkt_len = 14'd0; seed = 16'h0005; m_tready = 1'b1;
    step();
    start = 1'b0;
    step();
    tests_run++;
    if (m_tvalid !== 1'b0 || busy !== 1'b0 || tx_done !== 1'b1) begin
      tests_failed++;
      $display("FAIL zero_len: valid=%b busy=%b done=%b, required 0 0 1", m_tvalid, busy, tx_done);
    end

    start = 1'b1; pkt_len = 14'd3; seed = 16'h0020;
    step();
    for (int c = 1; c <= 12; c++) begin
      start   = (c == 1 || c == 4 || c == 5);
      pkt_len = 14'd5;
      if (m_tvalid && m_tready) begin
        hs++;
        last_data = m_tdata;
      end
      step();
    end
    start = 1'b0;
    exp = m_next(m_next(m_load(16'h0020)));
    tests_run++;
    if (hs !== 3 || last_data !== exp) begin
      tests_failed++;
      $display("FAIL ignored_starts: %0d beats last=%h, required 3 beats last=%h", hs, last_data, exp);
    end
    tests_run++;
    if (m_tvalid !== 1'b0 || busy !== 1'b0 || beat_cnt !== 14'd3) begin
      tests_failed++;
      $display("FAIL ignored_idle: valid=%b busy=%b cnt=%0d, required 0 0 3", m_tvalid, busy, beat_cnt);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] exp;
    start = 1'b1; pkt_len = 14'd5; seed = 16'h0040; m_tready = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    exp = m_next(m_next(m_load(16'h0040)));
    tests_run++;
    if (beat_cnt !== 14'd2 || m_tdata !== exp) begin
      tests_failed++;
      $display("FAIL rst_mid_pre: cnt=%0d data=%h, required 2 %h", beat_cnt, m_tdata, exp);
    end
    #2 areset_n = 1'b0;
    #1;
    tests_run++;
    if ({m_tvalid, m_tlast, busy, tx_done} !== 4'b0000 || m_tdata !== 16'h0 ||
        m_tkeep !== 2'b00 || beat_cnt !== 14'h0) begin
      tests_failed++;
      $display("FAIL rst_mid_async: valid=%b last=%b busy=%b done=%b data=%h keep=%b cnt=%0d, required all zero",
               m_tvalid, m_tlast, busy, tx_done, m_tdata, m_tkeep, beat_cnt);
    end
    #2 areset_n = 1'b1;
    step();
    tests_run++;
    if (m_tvalid !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_mid_stay_idle: valid=%b busy=%b, required 0 0", m_tvalid, busy);
    end
    start = 1'b1; pkt_len = 14'd2; seed = 16'h0010;
    step();
    start = 1'b0;
    exp = m_load(16'h0010);
    tests_run++;
    if (m_tvalid !== 1'b1 || m_tdata !== exp || m_tlast !== 1'b0) begin
      tests_failed++;
      $display("FAIL restart_beat0: valid=%b data=%h last=%b, required 1 %h 0", m_tvalid, m_tdata, m_tlast, exp);
    end
    step();
    exp = m_next(exp);
    tests_run++;
    if (m_tvalid !== 1'b1 || m_tdata !== exp || m_tlast !== 1'b1) begin
      tests_failed++;
      $display("FAIL restart_beat1: valid=%b data=%h last=%b, required 1 %h 1", m_tvalid, m_tdata, m_tlast, exp);
    end
    step();
    tests_run++;
    if (tx_done !== 1'b1 || beat_cnt !== 14'd2) begin
      tests_failed++;
      $display("FAIL restart_done: done=%b cnt=%0d, required 1 2", tx_done, beat_cnt);
    end
    wait_idle("restart");
  endtask

  task automatic test_max_len();
    logic [15:0] exp;
    int hs = 0, lasts = 0, bad = 0, n = 0;
    start = 1'b1; pkt_len = 14'h3FFF; seed = 16'h1234; m_tready = 1'b1;
    step();
    start = 1'b0;
    exp = m_load(16'h1234);
    while (!tx_done && n < 16500) begin
      if (m_tvalid) begin
        if (m_tdata !== exp) bad++;
        if (m_tlast) lasts++;
        hs++;
        exp = m_next(exp);
      end
      step();
      n++;
    end
    tests_run++;
    if (hs !== 16383 || lasts !== 1 || bad !== 0) begin
      tests_failed++;
      $display("FAIL maxlen_stream: beats=%0d tlasts=%0d bad_data=%0d, required 16383 1 0", hs, lasts, bad);
    end
    tests_run++;
    if (tx_done !== 1'b1 || beat_cnt !== 14'h3FFF) begin
      tests_failed++;
      $display("FAIL maxlen_cnt: done=%b cnt=%h, required 1 3fff", tx_done, beat_cnt);
    end
    wait_idle("maxlen");
  endtask

`ifdef AXIS_TX_PRBS_EN
  task automatic test_prbs();
    logic [47:0] got;
    start = 1'b1; pkt_len = 14'd3; seed = 16'h0001; m_tready = 1'b1;
    step();
    start = 1'b0;
    got[47:32] = m_tdata; step();
    got[31:16] = m_tdata; step();
    got[15:0]  = m_tdata;
    tests_run++;
    if (got !== 48'h0001_0002_0004) begin
      tests_failed++;
      $display("FAIL prbs_seq: got %h, required 000100020004", got);
    end
    wait_idle("prbs");
    start = 1'b1; pkt_len = 14'd1; seed = 16'h0000;
    step();
    start = 1'b0;
    tests_run++;
    if (m_tdata !== 16'h0001) begin
      tests_failed++;
      $display("FAIL prbs_zero_seed: got %h, required 0001", m_tdata);
    end
    wait_idle("prbs0");
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_single_and_wrap();
    test_ignored_starts();
    test_reset_mid();
    test_max_len();
`ifdef AXIS_TX_PRBS_EN
    test_prbs();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/axis_pkt_tx.md
Name: axis_pkt_tx

Overview:
- Single-clock AXI-Stream packet transmitter that drives the write (s_) side of the team's async AXIS FIFO.
- On a start command it emits one packet of pkt_len beats with a counter (or optional PRBS) payload, obeys tready backpressure, and marks the final beat with tlast.
- Raises a level tx_done once the packet has fully left the block. tx_done is intended to feed the FIFO's RECE_DONE read-side gate, through a synchroniser owned by the read domain.

Parameters:
DATA_WIDTH, 16, payload width in bits; must be a multiple of 8.
LEN_WIDTH, 14, width of the packet-length field; maximum packet is 2^LEN_WIDTH-1 beats.
GAP_CYCLES, 2, idle cycles inserted after a packet before a new start is accepted; 0 is legal.

Ports:
aclk  input  1  clock.
areset_n  input  1  reset.
start  input  1  one-cycle request to send a packet; sampled only in IDLE.
pkt_len  input  LEN_WIDTH  packet length in beats, sampled with start.
seed  input  DATA_WIDTH  payload of the first beat, sampled with start.
busy  output  1  high in SEND and GAP.
tx_done  output  1  level; packet completely transferred.
beat_cnt  output  LEN_WIDTH  number of beats handshaken in the current or last packet.
m_tdata  output  DATA_WIDTH  stream data.
m_tkeep  output  DATA_WIDTH/8  byte enables.
m_tvalid  output  1  stream valid.
m_tready  input  1  stream ready.
m_tlast  output  1  final beat of the packet.

Behaviour:
- Interface: one clock, aclk. Reset areset_n is asynchronous and active-low.
- All outputs are registered. Reset values: m_tvalid=0, m_tlast=0, m_tdata=0, m_tkeep=0, busy=0, tx_done=0, beat_cnt=0, state=IDLE.
- FSM states: IDLE, SEND, GAP.
- IDLE:
  - start=1 with pkt_len!=0: latch len, load m_tdata=seed, set m_tvalid=1, m_tkeep=all ones, m_tlast=(pkt_len==1), busy=1, tx_done=0, beat_cnt=0, go to SEND.
  - Latency: start in cycle N gives m_tvalid in cycle N+1.
  - start with pkt_len==0: ignored; no state change, tx_done unchanged.
- SEND:
  - Handshake is m_tvalid & m_tready. Without a handshake, m_tdata, m_tkeep and m_tlast hold stable and m_tvalid stays 1 (AXIS rule).
  - Non-final handshake: beat_cnt+1; m_tdata = m_tdata+1, wrapping mod 2^DATA_WIDTH; m_tlast = 1 when the next beat index equals len-1.
  - Final handshake (m_tlast=1): m_tvalid=0, m_tlast=0, beat_cnt=len, tx_done=1 next cycle. Go to GAP, or to IDLE if GAP_CYCLES=0.
  - Throughput: with tready held high, one beat per cycle and no bubbles.
- GAP:
  - Counts exactly GAP_CYCLES cycles, then goes to IDLE with busy=0.
  - start during GAP is ignored and is not queued.
- start during SEND is ignored.
- tx_done stays high until the next accepted start, where it clears in the same edge that raises m_tvalid.
- Reset asserted mid-packet: all state clears immediately. No tlast is emitted and tx_done=0. The downstream FIFO keeps a partial packet, which is acceptable by design.
- pkt_len = 2^LEN_WIDTH-1: beat_cnt reaches all ones without overflow.

Optional Feature:
- Macro: AXIS_TX_PRBS_EN.
- Defined:
  - Payload after the first beat is a Fibonacci LFSR: next = {d[14:0], d[15]^d[14]^d[12]^d[3]}.
  - DATA_WIDTH must be 16; elaboration fails otherwise.
  - seed==0 is replaced by 16'h0001 at load.
- Undefined: incrementing counter payload as above, with no LFSR logic synthesised.

Test Plan:
1. Reset release, start with pkt_len=4, seed=16'h00F0, tready=1 -> beats F0,F1,F2,F3 on consecutive cycles; tlast only on F3; tkeep=2'b11; tx_done=1 the cycle after; busy=0 after 2 GAP cycles; beat_cnt=4.
2. pkt_len=3, tready toggling 1,0,0,1,0,1 -> data/tlast held stable while tready=0; exactly 3 handshakes; tx_done follows the 3rd handshake.
3. pkt_len=1, seed=16'hFFFF -> single beat FFFF with tlast=1. Then pkt_len=2, seed=16'hFFFF -> beats FFFF, 0000 (wrap).
4. start with pkt_len=0 -> no tvalid, state IDLE. start pulses during SEND and during GAP -> ignored; only one packet is emitted.
5. areset_n low after the 2nd beat of a 5-beat packet -> outputs zero asynchronously; a restart with pkt_len=2, seed=16'h0010 gives 0010, 0011.
6. With AXIS_TX_PRBS_EN, seed=16'h0001, pkt_len=3 -> beats 0001, 0002, 0004; with seed=0 the first beat is 0001.
